// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM for the lw/sw/R-type/beq/addi/j subset.
// The Moore strobes are registered: they are decoded from the next state and
// then loaded into ctrl_q, so they change on the same edge as State.
// Two outputs are combinational: ALUControl while in EXECUTE follows Funct,
// and PCEn follows Zero.
// Optional feature: define MIPS_CTRL_BNE_EN to add bne (Op=000101). bne
// shares the BRANCH state with beq and takes the branch on ~Zero.
// Handshake: this block has no valid/ready channel. Op and Funct must be held
// stable from DECODE until the instruction returns to FETCH.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       PCEn,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_BAD = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] funct_alu;
  logic       funct_legal;
  logic       branch_cond;

  // Strobe pattern for a state. funct_ok gates RegWrite in ALUWB; it is
  // sampled while in EXECUTE, so ALUWB sees the Funct that EXECUTE saw.
  function automatic ctrl_t ctrl_for(input state_t s, input logic funct_ok);
    ctrl_t c;
    c = '0;
    c.alu_ctrl = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE:  c.alu_src_a = 1'b1;
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = funct_ok;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = ALU_SUB;
        c.branch    = 1'b1;
        c.pc_src    = 2'b01;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Funct field to ALU operation. Any unlisted code maps to 011 and
  // suppresses the ALUWB write-back.
  always_comb begin
    funct_alu = ALU_BAD;
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      6'b100111: funct_alu = ALU_NOR;
      default:   funct_alu = ALU_BAD;
    endcase
    funct_legal = (funct_alu != ALU_BAD);
  end

  // Next-state logic and the registered strobes for that next state.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d, funct_legal);
  end

  // State and strobe registers. Reset loads FETCH and its strobes, so the
  // only strobes visible after reset are the FETCH ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Branch condition: beq branches on Zero, bne (when enabled) on ~Zero.
  always_comb begin
`ifdef MIPS_CTRL_BNE_EN
    branch_cond = (Op == OP_BNE) ? ~Zero : Zero;
`else
    branch_cond = Zero;
`endif
  end

  assign IorD       = ctrl_q.iord;
  assign MemWrite   = ctrl_q.mem_write;
  assign IRWrite    = ctrl_q.ir_write;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign RegWrite   = ctrl_q.reg_write;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign PCWrite    = ctrl_q.pc_write;
  assign Branch     = ctrl_q.branch;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign PCSrc      = ctrl_q.pc_src;
  assign ALUControl = (state_q == S_EXECUTE) ? funct_alu : ctrl_q.alu_ctrl;
  assign PCEn       = ctrl_q.pc_write | (ctrl_q.branch & branch_cond);
  assign State      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level reference model plus
// directed and randomized instruction streams, with optional reset aborts.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCWrite, Branch, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .Branch(Branch), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .PCEn(PCEn), .State(State)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Bit positions inside the packed output vector
  localparam int B_PCEN = 4, B_PCSRC = 8, B_ALUC = 5, B_RW = 15, B_MTR = 16;
  localparam int B_RD = 17, B_IR = 18, B_MW = 19, B_PCW = 13;

  logic [20:0] dut_vec;
  assign dut_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    PCWrite, Branch, ALUSrcB, PCSrc, ALUControl, PCEn, State};

  logic [20:0] exp_q[$];
  logic [20:0] exp_now;
  logic [20:0] obs [0:4];
  int          obs_n;
  int          total = 0;
  int          bad   = 0;

  // ---------------- reference model ----------------
  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b100111: return 3'b100;
      default:   return 3'b011;
    endcase
  endfunction

  function automatic bit is_bne(input logic [5:0] op);
`ifdef MIPS_CTRL_BNE_EN
    return op == 6'b000101;
`else
    return 1'b0;
`endif
  endfunction

  // Number of cycles an instruction spends from FETCH to its last state.
  function automatic int seq_len(input logic [5:0] op);
    case (op)
      6'b100011:                     return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:          return 3;
      default:                       return is_bne(op) ? 3 : 2;
    endcase
  endfunction

  // State visited at cycle i of an instruction (cycle 0 is FETCH).
  function automatic logic [3:0] seq_at(input logic [5:0] op, input int i);
    logic [3:0] p [0:4];
    p = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    case (op)
      6'b100011: p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: p = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      6'b000000: p = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      6'b000100: p = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
      6'b001000: p = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
      6'b000010: p = '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0};
      default:   if (is_bne(op)) p = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
    endcase
    return p[i];
  endfunction

  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                          input logic [5:0] f, input logic z);
    logic iord, mw, ir, rd, mtr, rw, sa, pcw, br, take;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {iord, mw, ir, rd, mtr, rw, sa, pcw, br} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    take = is_bne(op) ? !z : z;
    case (st)
      4'd0:  begin ir = 1; pcw = 1; sb = 2'b01; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  iord = 1;
      4'd4:  begin mtr = 1; rw = 1; end
      4'd5:  begin iord = 1; mw = 1; end
      4'd6:  begin sa = 1; ac = alu_of(f); end
      4'd7:  begin rd = 1; rw = (alu_of(f) != 3'b011); end
      4'd8:  begin sa = 1; ac = 3'b110; br = 1; ps = 2'b01; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {iord, mw, ir, rd, mtr, rw, sa, pcw, br, sb, ps, ac, pcw | (br & take), st};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
      total++;
      if (dut_vec !== exp_now) begin
        bad++;
        $display("FAIL cycle_check t=%0t op=%b: got %h want %h", $time, Op, dut_vec, exp_now);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] mask_of(input int b);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < obs_n; i++) m[i] = obs[i][b];
    return m;
  endfunction

  // ---------------- driver ----------------
  // Runs one instruction from FETCH. rst_at >= 0 pulls reset_n low during
  // that cycle of the instruction, aborting it back to FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input logic z, input int rst_at);
    int n;
    n = seq_len(op);
    if (rst_at >= 0 && rst_at < n) n = rst_at + 1;
    Op = op; Funct = f; Zero = z;
    for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(seq_at(op, i), op, f, z));
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) reset_n = 1'b0;
      @(negedge clk);
      obs[i] = dut_vec;
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    obs_n = n;
  endtask

  logic [5:0] op_pool [0:7];
  logic [5:0] fn_pool [0:6];

  initial begin
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b000101, 6'b111111};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b100111, 6'b000001};
    reset_n = 1'b0; Op = 6'b100011; Funct = 6'b0; Zero = 1'b0;

    // Reset state: FETCH with its strobes, no other write strobe
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", State, 4'd0);
    check("rst_irwrite", IRWrite, 1'b1);
    check("rst_pcwrite", PCWrite, 1'b1);
    check("rst_pcen", PCEn, 1'b1);
    check("rst_srcb", ALUSrcB, 2'b01);
    check("rst_aluctrl", ALUControl, 3'b010);
    check("rst_memwrite", MemWrite, 1'b0);
    check("rst_regwrite", RegWrite, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // lw: 0,1,2,3,4 with RegWrite/MemtoReg only in MEMWB, IRWrite only in FETCH
    run_instr(6'b100011, 6'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) check("lw_state", obs[i][3:0], i);
    check("lw_regwrite_mask", mask_of(B_RW), 5'b10000);
    check("lw_memtoreg_mask", mask_of(B_MTR), 5'b10000);
    check("lw_irwrite_mask", mask_of(B_IR), 5'b00001);

    // R-type sub and illegal funct
    run_instr(6'b000000, 6'b100010, 1'b0, -1);
    check("lw_then_fetch", obs[0][3:0], 4'd0);
    check("sub_aluctrl", obs[2][B_ALUC +: 3], 3'b110);
    check("sub_regwrite", obs[3][B_RW], 1'b1);
    check("sub_regdst", obs[3][B_RD], 1'b1);
    run_instr(6'b000000, 6'b111111, 1'b0, -1);
    check("badfn_aluctrl", obs[2][B_ALUC +: 3], 3'b011);
    check("badfn_regwrite", obs[3][B_RW], 1'b0);

    // beq taken and not taken
    run_instr(6'b000100, 6'b0, 1'b1, -1);
    check("beq_z1_pcen", obs[2][B_PCEN], 1'b1);
    check("beq_z1_pcsrc", obs[2][B_PCSRC +: 2], 2'b01);
    run_instr(6'b000100, 6'b0, 1'b0, -1);
    check("beq_z0_pcen", obs[2][B_PCEN], 1'b0);

    // Illegal opcode: 0,1,0 and no write strobes in DECODE
    run_instr(6'b111111, 6'b0, 1'b0, -1);
    check("beq_then_fetch", obs[0][3:0], 4'd0);
    check("ill_state1", obs[1][3:0], 4'd1);
    check("ill_strobes", {obs[1][B_MW], obs[1][B_RW], obs[1][B_PCW], obs[1][B_IR]}, 4'b0);

    // Reset during MEMWRITE aborts the store
    run_instr(6'b101011, 6'b0, 1'b0, 3);
    check("ill_then_fetch", obs[0][3:0], 4'd0);
    check("sw_memwrite", obs[3][B_MW], 1'b1);
    run_instr(6'b000010, 6'b0, 1'b0, -1);
    check("sw_rst_state", obs[0][3:0], 4'd0);
    check("sw_rst_memwrite", obs[0][B_MW], 1'b0);

    // bne with Zero=0
    run_instr(6'b000101, 6'b0, 1'b0, -1);
`ifdef MIPS_CTRL_BNE_EN
    check("bne_state", obs[2][3:0], 4'd8);
    check("bne_pcen", obs[2][B_PCEN], 1'b1);
`else
    check("bne_ill_state1", obs[1][3:0], 4'd1);
    run_instr(6'b000000, 6'b100000, 1'b0, -1);
    check("bne_ill_fetch", obs[0][3:0], 4'd0);
`endif

    // Randomized instruction stream with occasional reset aborts
    for (int k = 0; k < 300; k++) begin
      logic [5:0] op, f;
      int ra;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                       : op_pool[$urandom_range(0, 7)];
      f  = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63))
                                       : fn_pool[$urandom_range(0, 6)];
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, f, 1'($urandom_range(0, 1)), ra);
    end

    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have these ports: reset_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-003 The block SHALL have these ports: Op  in  6  instruction opcode, valid from DECODE onward.
REQ-004 The block SHALL have these ports: Funct  in  6  R-type function field, valid from DECODE onward.
REQ-005 The block SHALL have these ports: Zero  in  1  ALU zero flag.
REQ-006 The block SHALL have these ports: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, Branch  out  1 each  datapath strobes and selects.
REQ-007 The block SHALL have these ports: ALUSrcB  out  2  00 RegB, 01 const 4, 10 SignImm, 11 SignImm<<2.
REQ-008 The block SHALL have these ports: PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
REQ-009 The block SHALL have these ports: ALUControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 undefined.
REQ-010 The block SHALL have these ports: PCEn  out  1  PCWrite | (Branch & branch condition).
REQ-011 The block SHALL have these ports: State  out  4  current state code, for debug.

Function
REQ-012 The FSM SHALL use these state codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-013 FETCH SHALL assert IRWrite=1 and PCWrite=1, and SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=010 and PCSrc=00; the next state SHALL be DECODE.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUControl=010, and SHALL branch on Op as follows: 100011/101011 to MEMADR, 000000 to EXECUTE, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP, any other value to FETCH.
REQ-015 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUControl=010, then go to MEMREAD if Op=100011, otherwise to MEMWRITE.
REQ-016 MEMREAD SHALL drive IorD=1 and go to MEMWB; MEMWB SHALL drive RegDst=0, MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-017 MEMWRITE SHALL drive IorD=1 and MemWrite=1, then go to FETCH.
REQ-018 EXECUTE SHALL drive ALUSrcA=1 and ALUSrcB=00, and SHALL decode Funct as follows: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR, any other value 011; the next state SHALL be ALUWB.
REQ-019 ALUWB SHALL drive RegDst=1 and MemtoReg=0, and SHALL assert RegWrite=1 only when the Funct captured in EXECUTE was legal (ALUControl was not 011); the next state SHALL be FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl=110, Branch=1 and PCSrc=01, then go to FETCH.
REQ-021 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUControl=010, then go to ADDIWB; ADDIWB SHALL drive RegDst=0, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-022 JUMP SHALL drive PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-023 Every output not listed for a state SHALL be 0 in that state (ALUControl=010 when unlisted).
REQ-024 All outputs SHALL be Moore functions of State, except that PCEn SHALL be combinational on Zero and ALUControl in EXECUTE SHALL be combinational on Funct.
REQ-025 Latencies SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
REQ-026 Unused state codes 12-15 SHALL drive the all-zero outputs and SHALL go to FETCH on the next edge.

Reset
REQ-027 When reset_n=0 on a rising edge, the next state SHALL be FETCH regardless of the current state, including mid-instruction.
REQ-028 During reset no write strobe (MemWrite, RegWrite, PCWrite, IRWrite) SHALL be committed beyond the FETCH outputs that follow reset.
REQ-029 Immediately after reset, State SHALL be 0 and all outputs SHALL equal the FETCH values.

Configuration
REQ-030 The feature macro SHALL be MIPS_CTRL_BNE_EN.
REQ-031 With MIPS_CTRL_BNE_EN defined, Op=000101 in DECODE SHALL go to BRANCH, and BRANCH SHALL compute PCEn = Branch & ~Zero for bne and Branch & Zero for beq.
REQ-032 With MIPS_CTRL_BNE_EN undefined, Op=000101 SHALL be treated as illegal and SHALL return to FETCH.

Verification
REQ-033 Reset then lw (Op=100011): the bench SHALL see State 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; IRWrite=1 only in state 0.
REQ-034 R-type with Funct=100010: in EXECUTE the bench SHALL see ALUControl=110, and in ALUWB RegWrite=1 and RegDst=1; with Funct=111111 it SHALL see ALUControl=011 and RegWrite=0 in ALUWB.
REQ-035 beq (Op=000100) with Zero=1: in BRANCH the bench SHALL see PCEn=1 and PCSrc=01; with Zero=0 it SHALL see PCEn=0, and State returns to 0 on the next edge in both cases.
REQ-036 Op=111111: the bench SHALL see State 0,1,0 with no write strobe asserted in state 1.
REQ-037 reset_n=0 asserted for one cycle while in MEMWRITE: on the next edge the bench SHALL see State=0 and MemWrite=0.
REQ-038 With MIPS_CTRL_BNE_EN defined, Op=000101 and Zero=0: the bench SHALL see PCEn=1 in BRANCH; without the macro it SHALL see State 0,1,0.
